// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and counter sizing.
package serializer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD      = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT_ACK  = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT_FREE = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE      = 3'd4;

  // Counter must reach bytes+extra without wrapping, so it needs one value past the byte count.
  function automatic int cnt_width(input int bytes, input int extra);
    return $clog2(bytes + extra + 1);
  endfunction

endpackage

// File: rtl/byte_xor_accum.sv
// Running XOR of every byte strobed to the UART; cleared when a new word is accepted.
// Only built when WORD_SERIALIZER_CHECKSUM_EN is defined.
`ifdef WORD_SERIALIZER_CHECKSUM_EN
module byte_xor_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (en)      acc <= acc ^ data;
  end

endmodule
`endif

// File: rtl/word_serializer.sv
// Splits an N-bit word into bytes and hands them one at a time to a UART using its busy handshake.
// Define WORD_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int N         = 256,
  parameter bit MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         tx_busy,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  output logic         busy,
  output logic         done
);

  localparam int BYTES = N / 8;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int CNT_W = cnt_width(BYTES, EXTRA);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES + EXTRA);

  logic [STATE_W-1:0] state;
  logic [N-1:0]       shreg;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         byte_q;
  logic [7:0]         data_byte;
  logic [7:0]         cur_byte;
  logic               fire;

  // Outputs are gated by rst so a reset asserted mid-word suppresses any strobe that cycle.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE) && !rst;
  assign done      = (state == S_DONE) && !rst;
  assign fire      = (state == S_LOAD) && !tx_busy && !rst;
  assign tx_valid  = fire;
  assign data_byte = MSB_FIRST ? shreg[N-1 -: 8] : shreg[7:0];
  assign tx_byte   = fire ? cur_byte : byte_q;

`ifdef WORD_SERIALIZER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CSUM_CNT = CNT_W'(BYTES);
  logic [7:0] csum;

  byte_xor_accum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (in_valid && in_ready),
    .en    (fire),
    .data  (cur_byte),
    .acc   (csum)
  );

  assign cur_byte = (cnt == CSUM_CNT) ? csum : data_byte;
`else
  assign cur_byte = data_byte;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      byte_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            cnt   <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!tx_busy) begin
            byte_q <= cur_byte;
            shreg  <= MSB_FIRST ? (shreg << 8) : (shreg >> 8);
            cnt    <= cnt + 1'b1;
            state  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (tx_busy) state <= S_WAIT_FREE;
        end
        S_WAIT_FREE: begin
          if (!tx_busy) state <= (cnt == LAST_CNT) ? S_DONE : S_LOAD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: two 32-bit serializers (MSB-first and LSB-first) share one UART busy model.
`timescale 1ns/1ps
module tb_word_serializer;

  localparam int N = 32;
`ifdef WORD_SERIALIZER_CHECKSUM_EN
  localparam int TOTAL = 5;
`else
  localparam int TOTAL = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         uart_busy = 1'b0;
  logic         force_busy = 1'b0;
  logic         tx_busy;

  logic       in_ready_m, tx_valid_m, busy_m, done_m;
  logic [7:0] tx_byte_m;
  logic       in_ready_l, tx_valid_l, busy_l, done_l;
  logic [7:0] tx_byte_l;

  assign tx_busy = uart_busy | force_busy;

  always #5 clk = ~clk;

  word_serializer #(.N(N), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_m),
    .tx_busy(tx_busy), .tx_byte(tx_byte_m), .tx_valid(tx_valid_m), .busy(busy_m), .done(done_m)
  );

  word_serializer #(.N(N), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
    .tx_busy(tx_busy), .tx_byte(tx_byte_l), .tx_valid(tx_valid_l), .busy(busy_l), .done(done_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor and UART model, sampled mid-cycle.
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  int   valid_cnt = 0, done_cnt = 0, bytes_at_done = 0;
  int   uart_len = 3, uart_cnt = 0;
  bit   valid_seen = 1'b0, rst_prev = 1'b1;
  logic [7:0] exp_last_m = '0, exp_last_l = '0;

  always @(negedge clk) begin
    #1;
    if (rst_prev) begin
      exp_last_m = '0;
      exp_last_l = '0;
    end
    if (!rst) begin
      check("valid_match", tx_valid_l, tx_valid_m);
      if (tx_valid_m) begin
        q_m.push_back(tx_byte_m);
        q_l.push_back(tx_byte_l);
        valid_cnt++;
        exp_last_m = tx_byte_m;
        exp_last_l = tx_byte_l;
      end else begin
        check("hold_m", tx_byte_m, exp_last_m);
        check("hold_l", tx_byte_l, exp_last_l);
      end
      if (done_m) begin
        done_cnt++;
        bytes_at_done = q_m.size();
        check("busy_in_done", busy_m, 1);
        check("ready_in_done", in_ready_m, 0);
      end
    end
    rst_prev = rst;
    if (uart_cnt != 0) begin
      uart_cnt--;
      if (uart_cnt == 0) uart_busy = 1'b0;
    end
    if (valid_seen) begin
      uart_busy = 1'b1;
      uart_cnt  = uart_len;
    end
    valid_seen = tx_valid_m && !rst;
  end

  // Reference: byte order and checksum derived directly from the word's byte values.
  function automatic void model(input logic [31:0] w, output logic [31:0] em,
                                output logic [31:0] el, output logic [7:0] ec);
    logic [7:0] b;
    em = w;
    el = '0;
    ec = '0;
    for (int i = 0; i < 4; i++) begin
      b  = 8'((w >> (8 * i)) & 32'hFF);
      el = el | (32'(b) << (8 * (3 - i)));
      ec = ec ^ b;
    end
  endfunction

  int d_base = 0;

  task automatic start_word(input logic [31:0] w, input int len, input bit need_free);
    bit ok = 1'b0;
    uart_len = len;
    for (int t = 0; t < 300; t++) begin
      if (in_ready_m && (!need_free || !tx_busy)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #2;
    end
    check("idle_wait", ok, 1);
    q_m.delete();
    q_l.delete();
    d_base   = done_cnt;
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic finish_word(input logic [31:0] em, input logic [31:0] el, input logic [7:0] ec);
    bit ok = 1'b0;
    logic [7:0] eb_m, eb_l;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk); #2;
      if (done_cnt != d_base) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_seen", ok, 1);
    check("byte_count_m", q_m.size(), TOTAL);
    check("byte_count_l", q_l.size(), TOTAL);
    check("bytes_at_done", bytes_at_done, TOTAL);
    for (int i = 0; i < TOTAL; i++) begin
      eb_m = (i < 4) ? em[8*(3-i) +: 8] : ec;
      eb_l = (i < 4) ? el[8*(3-i) +: 8] : ec;
      if (i < q_m.size()) check($sformatf("byte_m[%0d]", i), q_m[i], eb_m);
      if (i < q_l.size()) check($sformatf("byte_l[%0d]", i), q_l[i], eb_l);
    end
    @(negedge clk); #2;
    check("ready_after_done", in_ready_m, 1);
    check("busy_after_done", busy_m, 0);
    check("single_done", done_cnt - d_base, 1);
  endtask

  task automatic run_word(input logic [31:0] w, input int len, input bit inject,
                          input logic [31:0] em, input logic [31:0] el, input logic [7:0] ec);
    start_word(w, len, 1'b1);
    @(negedge clk); #2;
    check("first_valid_latency", tx_valid_m, 1);
    check("busy_in_flight", busy_m, 1);
    check("ready_in_flight", in_ready_m, 0);
    if (inject) begin
      @(negedge clk); #2;
      check("ready_during_inject", in_ready_m, 0);
      in_valid = 1'b1;
      in_data  = '1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
    end
    finish_word(em, el, ec);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_m;
    logic [31:0] exp_l;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] em, el, w;
    logic [7:0]  ec;
    int          v0, d0;
    bit          ok;

    vecs[0] = '{32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'h04};
    vecs[1] = '{32'h01020304, 32'h01020304, 32'h04030201, 8'h04};
    vecs[2] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE, 8'h22};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000, 8'h00};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00};
    vecs[5] = '{32'h80000001, 32'h80000001, 32'h01000080, 8'h81};
    vecs[6] = '{32'h12345678, 32'h12345678, 32'h78563412, 8'h08};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("rst_tx_valid", tx_valid_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_in_ready", in_ready_m, 0);
    check("rst_tx_byte_m", tx_byte_m, 0);
    check("rst_tx_byte_l", tx_byte_l, 0);
    rst = 1'b0;
    @(negedge clk); #2;
    check("ready_after_reset", in_ready_m, 1);
    check("busy_after_reset", busy_m, 0);

    // Directed table
    foreach (vecs[i]) run_word(vecs[i].word, 3, 1'b0, vecs[i].exp_m, vecs[i].exp_l, vecs[i].exp_csum);

    // Word offered while a word is in flight is ignored
    model(32'hA1B2C3D4, em, el, ec);
    run_word(32'hA1B2C3D4, 3, 1'b1, em, el, ec);

    // UART busy at accept holds off the first byte
    @(negedge clk); #2;
    force_busy = 1'b1;
    start_word(32'hA1B2C3D4, 3, 1'b0);
    v0 = valid_cnt;
    repeat (10) @(negedge clk);
    #2;
    check("no_valid_while_busy", valid_cnt - v0, 0);
    check("tx_valid_held_low", tx_valid_m, 0);
    @(negedge clk);
    force_busy = 1'b0;
    #2;
    check("valid_after_busy_fall", tx_valid_m, 1);
    finish_word(em, el, ec);

    // Reset in WAIT_FREE after the second byte
    start_word(32'hA1B2C3D4, 3, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #2;
      if (q_m.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("two_bytes_before_reset", ok, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    check("busy_during_rst", busy_m, 0);
    check("ready_during_rst", in_ready_m, 0);
    check("valid_during_rst", tx_valid_m, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("tx_byte_after_rst", tx_byte_m, 0);
    check("ready_after_rst", in_ready_m, 1);
    check("busy_after_rst", busy_m, 0);
    v0 = valid_cnt;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    #2;
    check("no_valid_after_rst", valid_cnt - v0, 0);
    check("no_done_after_rst", done_cnt - d0, 0);
    model(32'h01020304, em, el, ec);
    run_word(32'h01020304, 3, 1'b0, em, el, ec);

    // Randomized words and UART busy lengths
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      model(w, em, el, ec);
      run_word(w, int'($urandom_range(1, 5)), 1'b0, em, el, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter N, default 256: input word width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = byte order N-1..0; 0 = byte 0 first.
REQ-003 Derived constants: BYTES = N/8; CNT_W = $clog2(BYTES+1).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  in_data is offered.
REQ-007 in_data  input  N  word to serialize.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 tx_busy  input  1  UART transmitter is busy with a byte.
REQ-010 tx_byte  output  8  byte presented to the UART.
REQ-011 tx_valid  output  1  one-cycle strobe: tx_byte is valid.
REQ-012 busy  output  1  a word is in flight.
REQ-013 done  output  1  one-cycle pulse after the last byte's transmission completes.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, WAIT_ACK, WAIT_FREE, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a word SHALL be accepted when in_valid & in_ready.
REQ-016 On accept: capture in_data into shift register, byte counter = 0, go to LOAD; in_valid outside IDLE SHALL be ignored.
REQ-017 LOAD: if tx_busy = 0, drive tx_byte = current byte, tx_valid = 1 for exactly one cycle, shift by 8 (left if MSB_FIRST, else right), counter+1, go to WAIT_ACK; if tx_busy = 1, stay in LOAD with tx_valid = 0.
REQ-018 Accept-to-first-tx_valid latency SHALL be 1 cycle when tx_busy = 0.
REQ-019 WAIT_ACK: stay until tx_busy = 1, then go to WAIT_FREE.
REQ-020 WAIT_FREE: stay until tx_busy = 0; then go to LOAD if bytes remain, else to DONE.
REQ-021 DONE: done = 1 for one cycle, then go to IDLE; in_ready SHALL be 0 during DONE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Exactly BYTES tx_valid strobes per accepted word (plus REQ-029); the counter SHALL never wrap.
REQ-024 tx_byte SHALL hold its last value when tx_valid = 0.

Reset
REQ-025 rst = 1 at a clock edge SHALL force IDLE, counter = 0, shift register = 0, tx_byte = 0, tx_valid = 0, done = 0, busy = 0, in_ready = 0 for that cycle, and 1 in the following cycle.
REQ-026 Reset mid-word SHALL abandon the word with no further tx_valid and no done pulse.
REQ-027 rst SHALL take priority over every other input.

Configuration
REQ-028 Macro WORD_SERIALIZER_CHECKSUM_EN selects the checksum feature.
REQ-029 Defined: after the last data byte completes, one extra byte equal to the XOR of all BYTES data bytes SHALL be sent through LOAD/WAIT_ACK/WAIT_FREE before DONE; CNT_W SHALL then be $clog2(BYTES+2).
REQ-030 Undefined: no checksum byte; no checksum register exists.

Structure
REQ-031 A shared package serializer_pkg SHALL hold the FSM state enum and the helper that computes CNT_W.
REQ-032 One sub-module, byte_xor_accum, SHALL exist when the macro is defined. It clears on accept and XOR-accumulates each tx_valid byte.
REQ-033 Everything else SHALL be flat in word_serializer.

Verification
REQ-034 N=32, MSB_FIRST=1, word 0xA1B2C3D4, model UART busy 3 cycles per byte -> tx_byte sequence A1,B2,C3,D4; one done pulse; in_ready back to 1 after done.
REQ-035 Same word with MSB_FIRST=0 -> D4,C3,B2,A1.
REQ-036 Checksum macro defined, word 0xA1B2C3D4 -> A1,B2,C3,D4,04; done only after the 04 byte completes.
REQ-037 tx_busy held high 10 cycles at word accept -> no tx_valid until tx_busy falls; first tx_valid occurs on the cycle after it falls.
REQ-038 rst asserted in WAIT_FREE after byte 2 -> tx_valid and done stay 0; next word 0x01020304 serializes cleanly as 01,02,03,04.
REQ-039 in_valid pulsed with 0xFFFFFFFF while busy -> ignored; the in-flight word's bytes are unchanged.
